// File: rtl/tmds_gearbox.sv
// rtl/tmds_gearbox.sv - lockstep multi-lane symbol-to-word gearbox with underflow fill
// Optional underflow_count_o port enabled by macro TMDS_GEARBOX_UNDERFLOW_COUNT_EN.
module tmds_gearbox #(
    parameter int NUM_CHANNELS = 3,
    parameter int SYMBOL_WIDTH = 10,
    parameter int OUT_WIDTH    = 2,
    parameter logic [SYMBOL_WIDTH-1:0] FILL_SYMBOL = 10'b1101010100
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [NUM_CHANNELS*SYMBOL_WIDTH-1:0] symbol_i,
    input  logic                               symbol_valid_i,
    output logic                               symbol_ready_o,
    output logic [NUM_CHANNELS*OUT_WIDTH-1:0]  word_o,
    output logic                               word_valid_o,
    input  logic                               word_ready_i,
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
    output logic [15:0]                        underflow_count_o,
`endif
    output logic                               underflow_o
);
    localparam int BW = 2 * SYMBOL_WIDTH;
    localparam int LW = $clog2(BW + 1);
    localparam logic [LW-1:0] SW_L = LW'(SYMBOL_WIDTH);
    localparam logic [LW-1:0] OW_L = LW'(OUT_WIDTH);

    generate
        if (OUT_WIDTH < 1 || OUT_WIDTH > SYMBOL_WIDTH) begin : g_bad_out_width
            $error("tmds_gearbox: OUT_WIDTH must be in 1..SYMBOL_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {DISABLED, PRIME, RUN} state_t;

    state_t                            state_q, state_d;
    logic [LW-1:0]                     level_q, level_d;
    logic [BW-1:0]                     bits_q [NUM_CHANNELS];
    logic [BW-1:0]                     bits_d [NUM_CHANNELS];
    logic [NUM_CHANNELS*OUT_WIDTH-1:0] word_q, word_d;
    logic                              word_valid_q, word_valid_d;
    logic                              underflow_q, underflow_d;
    logic                              accept, fill_now, pop_now;
    logic [LW-1:0]                     lvl_fill, lvl_pop;
    logic [BW-1:0]                     lane_v;

    assign symbol_ready_o = (state_q != DISABLED) && (level_q <= SW_L);
    assign word_o         = word_q;
    assign word_valid_o   = word_valid_q;
    assign underflow_o    = underflow_q;

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        bits_d       = bits_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        underflow_d  = 1'b0;
        fill_now     = 1'b0;
        pop_now      = 1'b0;
        lvl_fill     = level_q;
        lvl_pop      = level_q;
        lane_v       = '0;
        accept       = symbol_valid_i && symbol_ready_o;
        if (!enable_i) begin
            state_d      = DISABLED;
            level_d      = '0;
            word_d       = '0;
            word_valid_d = 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) bits_d[c] = '0;
        end else begin
            case (state_q)
                DISABLED: state_d = PRIME;
                PRIME:    if (level_q >= SW_L) state_d = RUN;
                RUN: begin
                    pop_now  = word_ready_i;
                    fill_now = word_ready_i && (level_q < OW_L);
                end
                default:  state_d = DISABLED;
            endcase
            // Order within one edge: fill, then pop, then accepted symbol behind.
            lvl_fill    = fill_now ? level_q + SW_L : level_q;
            lvl_pop     = pop_now ? lvl_fill - OW_L : lvl_fill;
            level_d     = accept ? lvl_pop + SW_L : lvl_pop;
            underflow_d = fill_now;
            if (pop_now) word_valid_d = 1'b1;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                lane_v = bits_q[c];
                if (fill_now) lane_v = lane_v | (BW'(FILL_SYMBOL) << level_q);
                if (pop_now) begin
                    word_d[c*OUT_WIDTH +: OUT_WIDTH] = lane_v[OUT_WIDTH-1:0];
                    lane_v = lane_v >> OUT_WIDTH;
                end
                if (accept)
                    lane_v = lane_v | (BW'(symbol_i[c*SYMBOL_WIDTH +: SYMBOL_WIDTH]) << lvl_pop);
                bits_d[c] = lane_v;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= DISABLED;
            level_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) bits_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            underflow_q  <= underflow_d;
            for (int c = 0; c < NUM_CHANNELS; c++) bits_q[c] <= bits_d[c];
        end
    end

`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
    logic [15:0] underflow_count_q, underflow_count_d;

    always_comb begin
        underflow_count_d = underflow_count_q;
        if (!enable_i)
            underflow_count_d = '0;
        else if (underflow_d && underflow_count_q != 16'hFFFF)
            underflow_count_d = underflow_count_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) underflow_count_q <= '0;
        else         underflow_count_q <= underflow_count_d;
    end

    assign underflow_count_o = underflow_count_q;
`endif
endmodule

// File: tb/tb_tmds_gearbox.sv
// tb/tb_tmds_gearbox.sv - self-checking bench for tmds_gearbox against a bit-queue model
module tb_tmds_gearbox;
    localparam logic [9:0] FILL = 10'b1101010100;

    logic        clk = 1'b0;
    logic        rst, en, sv, wr;
    logic [29:0] sym;
    logic        sr, wv, uf;
    logic [5:0]  word;
    logic        en3, sv3, wr3;
    logic [29:0] sym3;
    logic        sr3, wv3, uf3;
    logic [8:0]  word3;
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
    logic [15:0] ucnt, ucnt3;
`endif

    int total = 0;
    int bad   = 0;

    // Reference: one queue entry per bit time, holding that bit of all three lanes.
    int         m_state;   // 0 disabled, 1 prime, 2 run
    logic [2:0] mq[$];
    logic [5:0] m_word;
    bit         m_valid, m_uf;

    always #5 clk = ~clk;

    tmds_gearbox u_dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .symbol_i(sym),
        .symbol_valid_i(sv), .symbol_ready_o(sr), .word_o(word),
        .word_valid_o(wv), .word_ready_i(wr),
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
        .underflow_count_o(ucnt),
`endif
        .underflow_o(uf)
    );

    tmds_gearbox #(.OUT_WIDTH(3)) u_dut3 (
        .clk_i(clk), .reset_i(rst), .enable_i(en3), .symbol_i(sym3),
        .symbol_valid_i(sv3), .symbol_ready_o(sr3), .word_o(word3),
        .word_valid_o(wv3), .word_ready_i(wr3),
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
        .underflow_count_o(ucnt3),
`endif
        .underflow_o(uf3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_state != 0) && (mq.size() <= 10);
    endfunction

    task automatic push_sym(input logic [29:0] s);
        for (int b = 0; b < 10; b++) mq.push_back({s[20+b], s[10+b], s[b]});
    endtask

    task automatic m_clear();
        m_state = 0; mq.delete(); m_word = '0; m_valid = 0; m_uf = 0;
    endtask

    // One clock: predict from pre-edge inputs, then compare every output at edge+1.
    task automatic step();
        bit acc, en_c, wr_c;
        logic [29:0] sym_c;
        logic [2:0]  col;
        acc = sv && m_ready();
        en_c = en; wr_c = wr; sym_c = sym;
        @(posedge clk); #1;
        if (!en_c) begin
            m_clear();
        end else begin
            m_uf = 0;
            if (m_state == 0) m_state = 1;
            else if (m_state == 1) begin
                if (mq.size() >= 10) m_state = 2;
            end else if (wr_c) begin
                if (mq.size() < 2) begin push_sym({FILL, FILL, FILL}); m_uf = 1; end
                for (int i = 0; i < 2; i++) begin
                    col = mq.pop_front();
                    for (int c = 0; c < 3; c++) m_word[c*2+i] = col[c];
                end
                m_valid = 1;
            end
            if (acc) push_sym(sym_c);
        end
        chk("ready", {31'd0, sr}, {31'd0, m_ready()});
        chk("word",  {26'd0, word}, {26'd0, m_word});
        chk("valid", {31'd0, wv}, {31'd0, m_valid});
        chk("underflow", {31'd0, uf}, {31'd0, m_uf});
    endtask

    task automatic do_reset();
        rst = 1'b1; #2;
        chk("rst_word",  {26'd0, word}, 32'd0);
        chk("rst_valid", {31'd0, wv}, 32'd0);
        chk("rst_uf",    {31'd0, uf}, 32'd0);
        chk("rst_ready", {31'd0, sr}, 32'd0);
`ifdef TMDS_GEARBOX_UNDERFLOW_COUNT_EN
        chk("rst_count", {16'd0, ucnt}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
    endtask

    initial begin
        logic [1:0] pat032 [5];
        logic [1:0] pat033 [10];
        logic [2:0] exp034 [6];
        logic [5:0] held;
        bit acc_pre;
        int k, n3;
        pat032 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
        pat033 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        exp034 = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b111, 3'b111};
        en = 0; sv = 0; wr = 0; sym = '0;
        en3 = 0; sv3 = 0; wr3 = 1; sym3 = '0;
        m_clear();
        rst = 1'b1;
        #1;
        do_reset();

        // Continuous feed of 3A5 on lane 0.
        en = 1; wr = 1; sv = 1; sym = {10'h155, 10'h0F0, 10'h3A5};
        k = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (wv) begin
                chk("p032_lane0", {30'd0, word[1:0]}, {30'd0, pat032[k%5]});
                chk("p032_uf", {31'd0, uf}, 32'd0);
                k++;
            end
        end
        chk("p032_count", (k > 20) ? 32'd1 : 32'd0, 32'd1);

        // Stall: ready low for 8 cycles while feeding continues.
        held = word; wr = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("p035_hold", {26'd0, word}, {26'd0, held});
            chk("p035_uf", {31'd0, uf}, 32'd0);
            if (mq.size() > 10) chk("p035_ready", {31'd0, sr}, 32'd0);
        end
        wr = 1;
        for (int i = 0; i < 5; i++) step();

        // One-cycle disable, then restart latency.
        en = 0; step();
        chk("p036_valid", {31'd0, wv}, 32'd0);
        chk("p036_ready", {31'd0, sr}, 32'd0);
        en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("p036_latency", {31'd0, wv}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Single symbol then fill symbols.
        do_reset();
        en = 1; wr = 1; sv = 1; sym = {10'h2AA, 10'h011, 10'h3A5};
        k = 0;
        for (int i = 0; i < 24; i++) begin
            acc_pre = sv && m_ready();
            step();
            if (acc_pre) sv = 0;
            if (wv && k < 15) begin
                chk("p033_lane0", {30'd0, word[1:0]}, {30'd0, (k < 5) ? pat032[k] : pat033[5 + (k%5)]});
                chk("p033_uf", {31'd0, uf}, (k > 0 && k % 5 == 0) ? 32'd1 : 32'd0);
                k++;
            end
        end
        chk("p033_count", k, 15);

        // Random traffic with occasional disables.
        for (int i = 0; i < 400; i++) begin
            sv  = ($urandom_range(0, 3) < ((i / 100) % 4)) ? 1'b1 : ($urandom_range(0, 7) == 0);
            wr  = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 49) != 0);
            sym = 30'($urandom);
            step();
        end

        // Mid-stream asynchronous reset in RUN.
        en = 1; wr = 1; sv = 1;
        for (int i = 0; i < 6; i++) step();
        chk("p037_in_run", {31'd0, wv}, 32'd1);
        do_reset();

        // OUT_WIDTH=3 straddling words.
        en = 0; sv = 0;
        en3 = 1; sv3 = 1; sym3 = '0; n3 = 0; k = 0;
        for (int i = 0; i < 20; i++) begin
            acc_pre = sv3 && sr3;
            step();
            if (acc_pre) begin
                n3++;
                if (n3 == 1) sym3 = 30'h3FF; else sv3 = 0;
            end
            if (wv3 && k < 6) begin
                chk("p034_lane0", {29'd0, word3[2:0]}, {29'd0, exp034[k]});
                k++;
            end
        end
        chk("p034_count", k, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
